dcache_wr_buffer: RTL and testbench

// Write-back queue between the data cache and axi_bridge's data write port. Absorbs dirty-line

---
 rtl/dcache_wr_buffer_if.sv | 15 +
 rtl/dcache_wr_buffer.sv | 100 ++++++++++
 tb/tb_dcache_wr_buffer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wr_buffer_if.sv
// Request/ready write port shared by the dcache push side and the bridge drain side.
// The master drives the payload and request; the slave answers with ready.
interface dcache_wr_buffer_if #(
  parameter int unsigned LINE_WIDTH = 128
) ();
  logic                  req;
  logic [2:0]            wr_type;
  logic [31:0]           addr;
  logic [3:0]            wstrb;
  logic [LINE_WIDTH-1:0] data;
  logic                  rdy;

  modport master (output req, wr_type, addr, wstrb, data, input rdy);
  modport slave  (input req, wr_type, addr, wstrb, data, output rdy);
endinterface

// File: rtl/dcache_wr_buffer.sv
// In-order write-back queue between the data cache and the AXI bridge write port.
// Absorbs evictions/uncached stores and flags reads that target a still-queued line.
module dcache_wr_buffer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned LINE_WIDTH   = 128,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  dcache_wr_buffer_if.slave            in_wr,
  dcache_wr_buffer_if.master           out_wr,
  input  logic                         bridge_idle,
  input  logic [31:0]                  query_addr,
  output logic                         query_hit,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty
);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned TAG_W = 32 - OFFSET_WIDTH;

  typedef struct packed {
    logic [2:0]            wr_type;
    logic [31:0]           addr;
    logic [3:0]            wstrb;
    logic [LINE_WIDTH-1:0] data;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_hit;
  entry_t            w_head_entry;

  assign in_wr.rdy     = (r_count != CW'(DEPTH));
  assign w_push        = in_wr.req & in_wr.rdy;
  assign w_head_entry  = r_mem[r_head];
  assign out_wr.req    = r_valid[r_head];
  assign out_wr.wr_type = w_head_entry.wr_type;
  assign out_wr.addr   = w_head_entry.addr;
  assign out_wr.wstrb  = w_head_entry.wstrb;
  assign out_wr.data   = w_head_entry.data;
  assign w_pop         = out_wr.req & out_wr.rdy;
  assign count         = r_count;
  assign empty         = (r_count == '0) & bridge_idle;
  assign query_hit     = w_hit;

  // Payload storage carries no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= '{wr_type: in_wr.wr_type, addr: in_wr.addr,
                         wstrb: in_wr.wstrb, data: in_wr.data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Line-granular match against every queued entry plus the push in flight.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] &&
          (r_mem[i].addr[31:OFFSET_WIDTH] == query_addr[31:OFFSET_WIDTH])) begin
        w_hit = 1'b1;
      end
    end
    if (w_push && (in_wr.addr[31:OFFSET_WIDTH] == query_addr[31:OFFSET_WIDTH])) begin
      w_hit = 1'b1;
    end
  end

  logic [TAG_W-1:0] w_unused_tag_width;
  assign w_unused_tag_width = '0;
endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Directed self-checking bench for dcache_wr_buffer: reset, drain latency, full/stall,
// address hit, pointer wrap against a queue model, and mid-operation reset.
module tb_dcache_wr_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        bridge_idle;
  logic [31:0] query_addr;
  logic        query_hit;
  logic [2:0]  count;
  logic        empty;
  int          checks = 0;
  int          errors = 0;

  dcache_wr_buffer_if #(.LINE_WIDTH(128)) in_if ();
  dcache_wr_buffer_if #(.LINE_WIDTH(128)) out_if ();

  dcache_wr_buffer #(.DEPTH(4), .LINE_WIDTH(128), .OFFSET_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_wr       (in_if.slave),
    .out_wr      (out_if.master),
    .bridge_idle (bridge_idle),
    .query_addr  (query_addr),
    .query_hit   (query_hit),
    .count       (count),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic req, input logic [31:0] addr, input logic [2:0] t);
    in_if.req     = req;
    in_if.addr    = addr;
    in_if.wr_type = t;
    in_if.wstrb   = 4'hF;
    in_if.data    = {4{addr ^ 32'hA5A5_0000}};
  endtask

  task automatic test_reset();
    reset = 1'b1; bridge_idle = 1'b1; query_addr = 32'h0;
    drive_push(1'b0, 32'h0, 3'b100);
    out_if.rdy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (out_if.req !== 1'b0) begin errors++; $display("FAIL reset_out_req got %b exp 0", out_if.req); end
    checks++; if (in_if.rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b exp 1", in_if.rdy); end
    checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL reset_query_hit got %b exp 0", query_hit); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty_idle got %b exp 1", empty); end
    bridge_idle = 1'b0; #1;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty_busy got %b exp 0", empty); end
    bridge_idle = 1'b1;
  endtask

  task automatic test_single_line();
    out_if.rdy = 1'b1;
    drive_push(1'b1, 32'h1C00_0040, 3'b100);
    #1;
    checks++; if (out_if.req !== 1'b0) begin errors++; $display("FAIL t1_req_same_cycle got %b exp 0", out_if.req); end
    tick();
    drive_push(1'b0, 32'h0, 3'b000);
    #1;
    checks++; if (out_if.req !== 1'b1) begin errors++; $display("FAIL t1_req_next got %b exp 1", out_if.req); end
    checks++; if (out_if.addr !== 32'h1C00_0040) begin errors++; $display("FAIL t1_addr got %h exp 1c000040", out_if.addr); end
    checks++; if (out_if.wr_type !== 3'b100) begin errors++; $display("FAIL t1_type got %b exp 100", out_if.wr_type); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL t1_count1 got %0d exp 1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL t1_empty_busy got %b exp 0", empty); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL t1_count0 got %0d exp 0", count); end
    checks++; if (out_if.req !== 1'b0) begin errors++; $display("FAIL t1_req_after got %b exp 0", out_if.req); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t1_empty got %b exp 1", empty); end
  endtask

  task automatic test_full_order();
    logic [31:0] exp_a;
    out_if.rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_push(1'b1, 32'(i) << 8, 3'b010);
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL t2_count4 got %0d exp 4", count); end
    checks++; if (in_if.rdy !== 1'b0) begin errors++; $display("FAIL t2_rdy_full got %b exp 0", in_if.rdy); end
    drive_push(1'b1, 32'h500, 3'b010);
    tick();
    drive_push(1'b0, 32'h0, 3'b000);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL t2_fifth_ignored got %0d exp 4", count); end
    checks++; if (out_if.addr !== 32'h100) begin errors++; $display("FAIL t2_head_stable got %h exp 100", out_if.addr); end
    out_if.rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_a = 32'(i) << 8;
      #1;
      checks++; if (out_if.addr !== exp_a) begin errors++; $display("FAIL t2_order got %h exp %h", out_if.addr, exp_a); end
      checks++; if (out_if.data !== {4{exp_a ^ 32'hA5A5_0000}}) begin errors++; $display("FAIL t2_data got %h", out_if.data); end
      tick();
    end
    checks++; if (out_if.req !== 1'b0) begin errors++; $display("FAIL t2_drained got %b exp 0", out_if.req); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_a;
    out_if.rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_push(1'b1, 32'(i) << 12, 3'b100);
      tick();
    end
    out_if.rdy = 1'b1;
    drive_push(1'b1, 32'h5000, 3'b100);
    #1;
    checks++; if (in_if.rdy !== 1'b0) begin errors++; $display("FAIL t3_rdy_full got %b exp 0", in_if.rdy); end
    tick();
    out_if.rdy = 1'b0;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL t3_count3 got %0d exp 3", count); end
    checks++; if (in_if.rdy !== 1'b1) begin errors++; $display("FAIL t3_rdy_after got %b exp 1", in_if.rdy); end
    tick();
    drive_push(1'b0, 32'h0, 3'b000);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL t3_count4 got %0d exp 4", count); end
    out_if.rdy = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      exp_a = 32'(i) << 12;
      #1;
      checks++; if (out_if.addr !== exp_a) begin errors++; $display("FAIL t3_order got %h exp %h", out_if.addr, exp_a); end
      tick();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL t3_count0 got %0d exp 0", count); end
  endtask

  task automatic test_query_hit();
    out_if.rdy = 1'b0;
    drive_push(1'b1, 32'h8000_1230, 3'b100);
    tick();
    drive_push(1'b0, 32'h0, 3'b000);
    query_addr = 32'h8000_123C; #1;
    checks++; if (query_hit !== 1'b1) begin errors++; $display("FAIL t4_hit_same_line got %b exp 1", query_hit); end
    query_addr = 32'h8000_1240; #1;
    checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL t4_miss_next_line got %b exp 0", query_hit); end
    drive_push(1'b1, 32'h8000_5000, 3'b010);
    query_addr = 32'h8000_5004; #1;
    checks++; if (query_hit !== 1'b1) begin errors++; $display("FAIL t4_hit_incoming got %b exp 1", query_hit); end
    drive_push(1'b0, 32'h8000_5000, 3'b010); #1;
    checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL t4_no_push_miss got %b exp 0", query_hit); end
    out_if.rdy = 1'b1;
    query_addr = 32'h8000_1230; #1;
    checks++; if (query_hit !== 1'b1) begin errors++; $display("FAIL t4_hit_popping got %b exp 1", query_hit); end
    tick();
    checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL t4_miss_after_pop got %b exp 0", query_hit); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL t4_count0 got %0d exp 0", count); end
  endtask

  task automatic test_wrap_model();
    logic [31:0]  mq_addr [$];
    logic [31:0]  a;
    logic         push_ok;
    logic         pop_ok;
    int           k = 0;
    for (int c = 0; c < 24; c++) begin
      a = 32'h9000 + (32'(k) << 4);
      drive_push(($urandom_range(0, 3) != 0), a, 3'b100);
      out_if.rdy = 1'($urandom_range(0, 1));
      #1;
      checks++; if (count !== 3'(mq_addr.size())) begin errors++; $display("FAIL t5_count got %0d exp %0d", count, mq_addr.size()); end
      checks++; if (out_if.req !== (mq_addr.size() != 0)) begin errors++; $display("FAIL t5_req got %b exp %b", out_if.req, mq_addr.size() != 0); end
      if (mq_addr.size() != 0) begin
        checks++; if (out_if.addr !== mq_addr[0]) begin errors++; $display("FAIL t5_addr got %h exp %h", out_if.addr, mq_addr[0]); end
        checks++; if (out_if.data !== {4{mq_addr[0] ^ 32'hA5A5_0000}}) begin errors++; $display("FAIL t5_data got %h", out_if.data); end
      end
      push_ok = in_if.req && (mq_addr.size() != 4);
      pop_ok  = out_if.rdy && (mq_addr.size() != 0);
      tick();
      if (pop_ok) void'(mq_addr.pop_front());
      if (push_ok) begin mq_addr.push_back(a); k++; end
    end
    drive_push(1'b0, 32'h0, 3'b000);
    out_if.rdy = 1'b1;
    for (int c = 0; c < 6 && mq_addr.size() != 0; c++) begin
      #1;
      checks++; if (out_if.addr !== mq_addr[0]) begin errors++; $display("FAIL t5_drain got %h exp %h", out_if.addr, mq_addr[0]); end
      tick();
      void'(mq_addr.pop_front());
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL t5_final_count got %0d exp 0", count); end
  endtask

  task automatic test_reset_midop();
    out_if.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 32'h7000_0000 + (32'(i) << 6), 3'b100);
      tick();
    end
    drive_push(1'b0, 32'h0, 3'b000);
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL t6_count3 got %0d exp 3", count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_if.rdy = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL t6_count0 got %0d exp 0", count); end
    checks++; if (out_if.req !== 1'b0) begin errors++; $display("FAIL t6_out_req got %b exp 0", out_if.req); end
    for (int i = 0; i < 3; i++) begin
      query_addr = 32'h7000_0000 + (32'(i) << 6); #1;
      checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL t6_query_hit got %b exp 0 addr %h", query_hit, query_addr); end
    end
    tick();
    checks++; if (out_if.req !== 1'b0) begin errors++; $display("FAIL t6_out_req_later got %b exp 0", out_if.req); end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_full_order();
    test_full_push_pop();
    test_query_hit();
    test_wrap_model();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
